// File: rtl/yx_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data wins ties until the streak limit, then fetch gets one grant.
module yx_mem_arbiter #(
   parameter int word_size    = 16,
   parameter int addr_size    = 16,
   parameter int max_d_streak = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 if_req,
   input  logic [addr_size-1:0] if_addr,
   output logic [word_size-1:0] if_rdata,
   output logic                 if_ack,
   input  logic                 d_req,
   input  logic                 d_we,
   input  logic [addr_size-1:0] d_addr,
   input  logic [word_size-1:0] d_wdata,
   output logic [word_size-1:0] d_rdata,
   output logic                 d_ack,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [addr_size-1:0] mem_addr,
   output logic [word_size-1:0] mem_wdata,
   input  logic [word_size-1:0] mem_rdata,
   input  logic                 mem_ack,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE, GNT_IF, GNT_D, DONE} state_t;

   localparam logic [3:0] streak_max = 4'(max_d_streak);

   state_t               state, nxt_state;
   logic [3:0]           d_streak, nxt_d_streak;
   logic                 nxt_mem_req, nxt_mem_we, nxt_if_ack, nxt_d_ack, nxt_busy;
   logic [addr_size-1:0] nxt_mem_addr;
   logic [word_size-1:0] nxt_mem_wdata, nxt_if_rdata, nxt_d_rdata;
   logic                 grant_d, grant_if;

   // Data wins unless fetch is waiting and the data streak has hit its limit.
   assign grant_d  = d_req && (!if_req || (d_streak < streak_max));
   assign grant_if = if_req && !grant_d;

   always_comb begin
      // NOTE: every nxt_ signal gets a default before the case so no latch is inferred.
      nxt_state     = state;
      nxt_d_streak  = d_streak;
      nxt_mem_req   = mem_req;
      nxt_mem_we    = mem_we;
      nxt_mem_addr  = mem_addr;
      nxt_mem_wdata = mem_wdata;
      nxt_if_rdata  = if_rdata;
      nxt_d_rdata   = d_rdata;
      nxt_if_ack    = 1'b0;
      nxt_d_ack     = 1'b0;

      case (state)
         IDLE: begin
            if (grant_d) begin
               nxt_state     = GNT_D;
               nxt_mem_req   = 1'b1;
               nxt_mem_we    = d_we;
               nxt_mem_addr  = d_addr;
               nxt_mem_wdata = d_wdata;
               if (!if_req)
                  nxt_d_streak = '0;
               else if (d_streak != streak_max)
                  nxt_d_streak = d_streak + 4'd1;
            end else if (grant_if) begin
               nxt_state    = GNT_IF;
               nxt_mem_req  = 1'b1;
               nxt_mem_we   = 1'b0;
               nxt_mem_addr = if_addr;
               nxt_d_streak = '0;
            end
         end
         GNT_IF: begin
            if (mem_ack) begin
               nxt_state    = DONE;
               nxt_mem_req  = 1'b0;
               nxt_mem_we   = 1'b0;
               nxt_if_rdata = mem_rdata;
               nxt_if_ack   = 1'b1;
            end
         end
         GNT_D: begin
            if (mem_ack) begin
               nxt_state   = DONE;
               nxt_mem_req = 1'b0;
               nxt_mem_we  = 1'b0;
               nxt_d_rdata = mem_rdata;
               nxt_d_ack   = 1'b1;
            end
         end
         DONE:    nxt_state = IDLE;
         default: nxt_state = IDLE;
      endcase

      nxt_busy = (nxt_state != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         d_streak  <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         d_rdata   <= '0;
         if_ack    <= 1'b0;
         d_ack     <= 1'b0;
         busy      <= 1'b0;
      end else begin
         // NOTE: registered state uses non-blocking assignments only, so every flop sees pre-edge values.
         state     <= nxt_state;
         d_streak  <= nxt_d_streak;
         mem_req   <= nxt_mem_req;
         mem_we    <= nxt_mem_we;
         mem_addr  <= nxt_mem_addr;
         mem_wdata <= nxt_mem_wdata;
         if_rdata  <= nxt_if_rdata;
         d_rdata   <= nxt_d_rdata;
         if_ack    <= nxt_if_ack;
         d_ack     <= nxt_d_ack;
         busy      <= nxt_busy;
      end
   end

endmodule

// File: tb/tb_yx_mem_arbiter.sv
// Directed bench for yx_mem_arbiter: table of single transfers plus
// hand-written reset, tie-break, starvation and zero-wait sequences.
module tb_yx_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, d_req, d_we, mem_ack;
   logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic        if_ack, d_ack, mem_req, mem_we, busy;

   int total = 0;
   int bad   = 0;

   // Expected-value model for registers that hold across transfers.
   logic [15:0] exp_wdata, exp_if_rdata, exp_d_rdata;

   typedef struct {
      bit          is_d;
      bit          we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      int          lat;
      bit          exp_we;
      bit          exp_if_ack;
      bit          exp_d_ack;
   } vec_t;

   vec_t vecs[6];

   yx_mem_arbiter #(.word_size(16), .addr_size(16), .max_d_streak(3)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      if (v.is_d) begin
         d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
         exp_wdata = v.wdata;
      end else begin
         if_req = 1'b1; if_addr = v.addr;
      end
      mem_rdata = v.rdata;
      mem_ack   = 1'b0;
      for (int k = 1; k <= v.lat; k++) begin
         tick();
         check("vec mem_req", mem_req, 1);
         check("vec mem_addr", mem_addr, v.addr);
         check("vec mem_we", mem_we, v.exp_we);
         check("vec mem_wdata", mem_wdata, exp_wdata);
         check("vec busy grant", busy, 1);
         check("vec ack in grant", if_ack | d_ack, 0);
         d_addr  = ~v.addr;
         if_addr = ~v.addr;
         d_wdata = ~v.wdata;
         d_we    = ~v.we;
         if (k == v.lat) mem_ack = 1'b1;
      end
      tick();
      if (v.is_d) exp_d_rdata = v.rdata;
      else        exp_if_rdata = v.rdata;
      check("vec done mem_req", mem_req, 0);
      check("vec done mem_we", mem_we, 0);
      check("vec if_ack", if_ack, v.exp_if_ack);
      check("vec d_ack", d_ack, v.exp_d_ack);
      check("vec done busy", busy, 1);
      check("vec if_rdata", if_rdata, exp_if_rdata);
      check("vec d_rdata", d_rdata, exp_d_rdata);
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
      tick();
      check("vec idle acks", if_ack | d_ack, 0);
      check("vec idle busy", busy, 0);
      check("vec hold if_rdata", if_rdata, exp_if_rdata);
      check("vec hold d_rdata", d_rdata, exp_d_rdata);
   endtask

   initial begin
      logic exp_d[8];
      exp_d = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

      //            is_d  we    addr      wdata     rdata     lat we   ifa  da
      vecs[0] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'h6A05, 1, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 16'h8002, 16'hBEEF, 16'h0BAD, 4, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{1'b0, 1'b0, 16'hFFFE, 16'h0000, 16'hA5A5, 3, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 16'h1234, 16'h00C3, 16'h5555, 2, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{1'b1, 1'b0, 16'h0000, 16'hFFFF, 16'hFFFF, 1, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{1'b1, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1, 1'b1, 1'b0, 1'b1};

      rst = 1'b0;
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
      exp_wdata = '0; exp_if_rdata = '0; exp_d_rdata = '0;

      #2;
      check("rst mem_req", mem_req, 0);
      check("rst mem_we", mem_we, 0);
      check("rst mem_addr", mem_addr, 0);
      check("rst mem_wdata", mem_wdata, 0);
      check("rst acks", if_ack | d_ack, 0);
      check("rst if_rdata", if_rdata, 0);
      check("rst d_rdata", d_rdata, 0);
      check("rst busy", busy, 0);
      tick();
      rst = 1'b1;
      tick();

      // Reset in the middle of a stalled store.
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h2222; d_wdata = 16'h3333;
      tick();
      check("midrst grant mem_req", mem_req, 1);
      tick();
      check("midrst still waiting", mem_req, 1);
      rst = 1'b0;
      #1;
      check("midrst mem_req drop", mem_req, 0);
      check("midrst busy drop", busy, 0);
      check("midrst mem_addr", mem_addr, 0);
      check("midrst no d_ack", d_ack, 0);
      d_req = 1'b0; d_we = 1'b0;
      tick();
      check("midrst held no d_ack", d_ack, 0);
      rst = 1'b1;
      tick();
      check("midrst idle busy", busy, 0);
      check("midrst idle mem_req", mem_req, 0);
      check("midrst idle d_ack", d_ack, 0);

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Simultaneous requests: data first, fetch on the next IDLE.
      if_req = 1'b1; if_addr = 16'h0002;
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100; d_wdata = 16'h0777;
      mem_rdata = 16'h1111; mem_ack = 1'b0;
      exp_wdata = 16'h0777;
      tick();
      check("tie first addr", mem_addr, 16'h0100);
      check("tie first we", mem_we, 0);
      mem_ack = 1'b1;
      tick();
      check("tie d_ack", d_ack, 1);
      check("tie no if_ack", if_ack, 0);
      check("tie d_rdata", d_rdata, 16'h1111);
      d_req = 1'b0; mem_ack = 1'b0;
      tick();
      check("tie idle busy", busy, 0);
      tick();
      check("tie second addr", mem_addr, 16'h0002);
      check("tie second req", mem_req, 1);
      check("tie second wdata", mem_wdata, exp_wdata);
      mem_ack = 1'b1; mem_rdata = 16'h2222;
      tick();
      check("tie if_ack", if_ack, 1);
      check("tie if_rdata", if_rdata, 16'h2222);
      if_req = 1'b0; mem_ack = 1'b0;
      tick();
      check("tie end busy", busy, 0);

      // Streak bound with zero-wait memory: D,D,D,IF repeating, 3 cycles each.
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0D00; d_wdata = 16'h0000;
      if_req = 1'b1; if_addr = 16'h0F00;
      mem_ack = 1'b1; mem_rdata = 16'h4242;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("streak grant addr", mem_addr, exp_d[i] ? 16'h0D00 : 16'h0F00);
         check("streak grant busy", busy, 1);
         tick();
         check("streak d_ack", d_ack, exp_d[i]);
         check("streak if_ack", if_ack, !exp_d[i]);
         check("streak done busy", busy, 1);
         tick();
         check("streak idle busy", busy, 0);
         check("streak idle mem_req", mem_req, 0);
      end
      d_req = 1'b0; if_req = 1'b0; mem_ack = 1'b0;
      tick();
      check("final idle busy", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
